// File: rtl/regfile_arbiter_if.sv
// Request/response, clear-control and register-file bus of regfile_arbiter.
// master = requesters plus register file; slave = the arbiter.
interface regfile_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          req0_valid;
    logic          req0_we;
    logic [AW-1:0] req0_ra;
    logic [AW-1:0] req0_rb;
    logic [AW-1:0] req0_wa;
    logic [DW-1:0] req0_wd;
    logic          req0_ready;

    logic          req1_valid;
    logic          req1_we;
    logic [AW-1:0] req1_ra;
    logic [AW-1:0] req1_rb;
    logic [AW-1:0] req1_wa;
    logic [DW-1:0] req1_wd;
    logic          req1_ready;

    logic          rsp0_valid;
    logic [DW-1:0] rsp0_d1;
    logic [DW-1:0] rsp0_d2;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_d1;
    logic [DW-1:0] rsp1_d2;

    logic          clear_start;
    logic          clear_busy;

    logic [AW-1:0] rf_reg1;
    logic [AW-1:0] rf_reg2;
    logic [AW-1:0] rf_reg_w;
    logic          rf_do_write;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_data1;
    logic [DW-1:0] rf_data2;

    modport master (
        output req0_valid, req0_we, req0_ra, req0_rb,
        output req0_wa, req0_wd,
        output req1_valid, req1_we, req1_ra, req1_rb,
        output req1_wa, req1_wd,
        output clear_start, rf_data1, rf_data2,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_d1, rsp0_d2,
        input  rsp1_valid, rsp1_d1, rsp1_d2,
        input  clear_busy,
        input  rf_reg1, rf_reg2, rf_reg_w,
        input  rf_do_write, rf_write_data
    );

    modport slave (
        input  req0_valid, req0_we, req0_ra, req0_rb,
        input  req0_wa, req0_wd,
        input  req1_valid, req1_we, req1_ra, req1_rb,
        input  req1_wa, req1_wd,
        input  clear_start, rf_data1, rf_data2,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_d1, rsp0_d2,
        output rsp1_valid, rsp1_d1, rsp1_d2,
        output clear_busy,
        output rf_reg1, rf_reg2, rf_reg_w,
        output rf_do_write, rf_write_data
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-port arbiter and clear sequencer in front of a 4x8 register file.
// Define REGARB_STARVE_GUARD_EN to add the port-1 starvation guard.
module regfile_arbiter #(
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int NREG     = 2**AW,
    parameter int MAX_WAIT = 7
) (
    input logic              clk,
    input logic              reset,
    regfile_arbiter_if.slave bus
);
    typedef enum logic {ARB, CLEAR} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rv0_q, rv1_q;
    logic [DW-1:0] r0d1_q, r0d2_q;
    logic [DW-1:0] r1d1_q, r1d2_q;

    logic g0, g1, rd0, rd1;
    logic conflict, p1_wins, starve;

    assign conflict = bus.req0_valid && bus.req1_valid
                   && (bus.req0_we == bus.req1_we);
    assign p1_wins  = conflict && starve;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        g0                = 1'b0;
        g1                = 1'b0;
        bus.rf_reg1       = '0;
        bus.rf_reg2       = '0;
        bus.rf_reg_w      = '0;
        bus.rf_do_write   = 1'b0;
        bus.rf_write_data = '0;
        if (reset) begin
            unique case (state_q)
                ARB: begin
                    if (bus.clear_start) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        g0 = bus.req0_valid && !p1_wins;
                        g1 = bus.req1_valid
                          && (!conflict || p1_wins);
                        if (g0 && bus.req0_we) begin
                            bus.rf_do_write   = 1'b1;
                            bus.rf_reg_w      = bus.req0_wa;
                            bus.rf_write_data = bus.req0_wd;
                        end else if (g1 && bus.req1_we) begin
                            bus.rf_do_write   = 1'b1;
                            bus.rf_reg_w      = bus.req1_wa;
                            bus.rf_write_data = bus.req1_wd;
                        end
                        if (g0 && !bus.req0_we) begin
                            bus.rf_reg1 = bus.req0_ra;
                            bus.rf_reg2 = bus.req0_rb;
                        end else if (g1 && !bus.req1_we) begin
                            bus.rf_reg1 = bus.req1_ra;
                            bus.rf_reg2 = bus.req1_rb;
                        end
                    end
                end
                CLEAR: begin
                    bus.rf_do_write = 1'b1;
                    bus.rf_reg_w    = cnt_q;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == AW'(NREG - 1)) begin
                        cnt_d   = '0;
                        state_d = ARB;
                    end
                end
            endcase
        end
    end

    assign rd0 = g0 && !bus.req0_we;
    assign rd1 = g1 && !bus.req1_we;

    // Read data is registered at the posedge after the grant; the register
    // file has already settled rf_data on the preceding negedge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB;
            cnt_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            r0d1_q  <= '0;
            r0d2_q  <= '0;
            r1d1_q  <= '0;
            r1d2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv0_q   <= rd0;
            rv1_q   <= rd1;
            if (rd0) begin
                r0d1_q <= bus.rf_data1;
                r0d2_q <= bus.rf_data2;
            end
            if (rd1) begin
                r1d1_q <= bus.rf_data1;
                r1d2_q <= bus.rf_data2;
            end
        end
    end

    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign bus.rsp0_valid = rv0_q;
    assign bus.rsp0_d1    = r0d1_q;
    assign bus.rsp0_d2    = r0d2_q;
    assign bus.rsp1_valid = rv1_q;
    assign bus.rsp1_d1    = r1d1_q;
    assign bus.rsp1_d2    = r1d2_q;
    assign bus.clear_busy = (state_q == CLEAR);

`ifdef REGARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_q, wait_d;

    assign starve = (wait_q == WW'(MAX_WAIT));

    always_comb begin
        wait_d = wait_q;
        if (!bus.req1_valid || g1)
            wait_d = '0;
        else if (!starve)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            wait_q <= '0;
        else
            wait_q <= wait_d;
    end
`else
    logic unused_max_wait;

    assign unused_max_wait = ^MAX_WAIT;
    assign starve          = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter against a transaction-level model
// of the register file contents, grants, clear sequence and wait counter.
module tb_regfile_arbiter;
    localparam int DW       = 8;
    localparam int AW       = 2;
    localparam int NREG     = 4;
    localparam int MAX_WAIT = 7;
`ifdef REGARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } req_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    regfile_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_arbiter #(
        .DW(DW), .AW(AW), .NREG(NREG), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] rf_mem [NREG] = '{default: '0};

    always @(posedge clk)
        if (bus.rf_do_write)
            rf_mem[bus.rf_reg_w] <= bus.rf_write_data;

    always @(negedge clk) begin
        bus.rf_data1 <= rf_mem[bus.rf_reg1];
        bus.rf_data2 <= rf_mem[bus.rf_reg2];
    end

    req_t          s0, s1;
    logic [DW-1:0] mdl [NREG];
    int            clr_left;
    int            waitc;
    logic          e_rv [2];
    logic [DW-1:0] e_d1 [2];
    logic [DW-1:0] e_d2 [2];
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic cs);
        reset          = rn;
        bus.req0_valid = s0.v;
        bus.req0_we    = s0.we;
        bus.req0_ra    = s0.ra;
        bus.req0_rb    = s0.rb;
        bus.req0_wa    = s0.wa;
        bus.req0_wd    = s0.wd;
        bus.req1_valid = s1.v;
        bus.req1_we    = s1.we;
        bus.req1_ra    = s1.ra;
        bus.req1_rb    = s1.rb;
        bus.req1_wa    = s1.wa;
        bus.req1_wd    = s1.wd;
        bus.clear_start = cs;
    endtask

    function automatic int next_wait(input logic v1, input logic g1);
        if (!v1 || g1)
            return 0;
        return (waitc < MAX_WAIT) ? waitc + 1 : waitc;
    endfunction

    task automatic cyc(input logic rn, input logic cs);
        logic g0, g1, wr;
        @(posedge clk);
        #1;
        chk("rsp0_v", bus.rsp0_valid, e_rv[0]);
        chk("rsp0_d1", bus.rsp0_d1, e_d1[0]);
        chk("rsp0_d2", bus.rsp0_d2, e_d2[0]);
        chk("rsp1_v", bus.rsp1_valid, e_rv[1]);
        chk("rsp1_d1", bus.rsp1_d1, e_d1[1]);
        chk("rsp1_d2", bus.rsp1_d2, e_d2[1]);
        drive(rn, cs);
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        wr = 1'b0;
        chk("busy", bus.clear_busy, clr_left > 0);
        if (!rn) begin
            clr_left = 0;
            waitc    = 0;
            for (int p = 0; p < 2; p++) begin
                e_rv[p] = 1'b0;
                e_d1[p] = '0;
                e_d2[p] = '0;
            end
        end else if (clr_left > 0) begin
            wr = 1'b1;
            mdl[NREG - clr_left] = '0;
            clr_left--;
            waitc   = next_wait(s1.v, 1'b0);
            e_rv[0] = 1'b0;
            e_rv[1] = 1'b0;
        end else if (cs) begin
            clr_left = NREG;
            waitc    = next_wait(s1.v, 1'b0);
            e_rv[0]  = 1'b0;
            e_rv[1]  = 1'b0;
        end else begin
            if (s0.v && s1.v && s0.we == s1.we) begin
                g1 = GUARD && waitc == MAX_WAIT;
                g0 = !g1;
            end else begin
                g0 = s0.v;
                g1 = s1.v;
            end
            e_rv[0] = g0 && !s0.we;
            e_rv[1] = g1 && !s1.we;
            if (e_rv[0]) begin
                e_d1[0] = mdl[s0.ra];
                e_d2[0] = mdl[s0.rb];
            end
            if (e_rv[1]) begin
                e_d1[1] = mdl[s1.ra];
                e_d2[1] = mdl[s1.rb];
            end
            if (g0 && s0.we) begin
                mdl[s0.wa] = s0.wd;
                wr = 1'b1;
            end
            if (g1 && s1.we) begin
                mdl[s1.wa] = s1.wd;
                wr = 1'b1;
            end
            waitc = next_wait(s1.v, g1);
        end
        chk("rdy0", bus.req0_ready, g0);
        chk("rdy1", bus.req1_ready, g1);
        chk("rf_we", bus.rf_do_write, wr);
    endtask

    task automatic idle();
        s0 = '0;
        s1 = '0;
        cyc(1'b1, 1'b0);
    endtask

    function automatic req_t mk(input logic we, input int a,
                                input int b, input int d);
        req_t r;
        r    = '0;
        r.v  = 1'b1;
        r.we = we;
        r.ra = AW'(a);
        r.rb = AW'(b);
        r.wa = AW'(a);
        r.wd = DW'(d);
        return r;
    endfunction

    task automatic wr0(input int a, input int d);
        s0 = mk(1'b1, a, 0, d);
        s1 = '0;
        cyc(1'b1, 1'b0);
    endtask

    task automatic rd0(input int a, input int b);
        s0 = mk(1'b0, a, b, 0);
        s1 = '0;
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        int nb;
        int first;
        s0       = '0;
        s1       = '0;
        clr_left = 0;
        waitc    = 0;
        for (int i = 0; i < NREG; i++)
            mdl[i] = '0;
        for (int p = 0; p < 2; p++) begin
            e_rv[p] = 1'b0;
            e_d1[p] = '0;
            e_d2[p] = '0;
        end
        drive(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        wr0(2, 8'hA5);
        rd0(2, 0);
        idle();
        chk("tp1_v", bus.rsp0_valid, 1);
        chk("tp1_d1", bus.rsp0_d1, 8'hA5);
        chk("tp1_d2", bus.rsp0_d2, 8'h00);

        wr0(1, 8'h11);
        s0 = mk(1'b1, 1, 0, 8'h3C);
        s1 = mk(1'b0, 1, 1, 0);
        cyc(1'b1, 1'b0);
        chk("tp2_rdy", {bus.req0_ready, bus.req1_ready}, 2'b11);
        idle();
        chk("tp2_old", bus.rsp1_d1, 8'h11);
        rd0(1, 1);
        idle();
        chk("tp2_new", bus.rsp0_d1, 8'h3C);

        s0 = mk(1'b1, 3, 0, 8'h01);
        s1 = mk(1'b1, 3, 0, 8'h02);
        cyc(1'b1, 1'b0);
        chk("tp3_rdy1", bus.req1_ready, 0);
        s0 = '0;
        cyc(1'b1, 1'b0);
        chk("tp3_g1", bus.req1_ready, 1);
        rd0(3, 3);
        idle();
        chk("tp3_reg3", bus.rsp0_d1, 8'h02);

        for (int i = 0; i < NREG; i++)
            wr0(i, 8'h11 * (i + 1));
        s0 = mk(1'b0, 1, 2, 0);
        s1 = '0;
        cyc(1'b1, 1'b1);
        nb = 0;
        repeat (6) begin
            cyc(1'b1, 1'b0);
            nb += int'(bus.clear_busy);
        end
        chk("tp4_busy", nb, 4);
        rd0(0, 1);
        rd0(2, 3);
        chk("tp4_r01", {bus.rsp0_d1, bus.rsp0_d2}, 16'h0);
        idle();
        chk("tp4_r23", {bus.rsp0_d1, bus.rsp0_d2}, 16'h0);

        for (int i = 0; i < NREG; i++)
            wr0(i, 8'h11 * (i + 1));
        s0 = '0;
        cyc(1'b1, 1'b1);
        idle();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("tp5_busy", bus.clear_busy, 0);
        chk("tp5_rv", bus.rsp0_valid, 0);
        rd0(0, 2);
        idle();
        chk("tp5_r0", bus.rsp0_d1, 8'h00);
        chk("tp5_r2", bus.rsp0_d2, 8'h33);

        idle();
        s0    = mk(1'b0, 0, 1, 0);
        s1    = mk(1'b0, 2, 3, 0);
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0);
            if (first == 0 && bus.req1_ready)
                first = i;
        end
        chk("starve", first, GUARD ? 8 : 0);

        repeat (400) begin
            s0    = req_t'({$urandom, $urandom});
            s1    = req_t'({$urandom, $urandom});
            s0.v  = ($urandom_range(0, 3) != 0);
            s1.v  = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 39) != 0,
                $urandom_range(0, 15) == 0);
        end
        idle();
        idle();
        for (int i = 0; i < NREG; i++)
            chk("rf_final", rf_mem[i], mdl[i]);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the 4-entry x 8-bit register file between two requesters: port 0 (core datapath) and port 1 (loader/debug).
- Arbitrates the single write port and the read-address pair.
- Returns read data one cycle after grant.
- Contains a clear sequencer that zeroes all registers through the write port.
- Sits between the requesters and the register file; drives all register-file address, data and write inputs.

Parameters:
- DW, 8, data width
- AW, 2, register address width
- NREG, 4, number of registers cleared by the clear sequence (2**AW)
- MAX_WAIT, 7, starvation limit for port 1 (used only with the optional feature)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-low; state clears on posedge clk while reset==0
- reqN_valid  in  1  (N=0,1) request present
- reqN_we  in  1  1 = write, 0 = read
- reqN_ra, reqN_rb  in  AW  read addresses
- reqN_wa  in  AW  write address
- reqN_wd  in  DW  write data
- reqN_ready  out  1  request accepted this cycle (combinational)
- rspN_valid  out  1  one-cycle pulse, read data valid
- rspN_d1, rspN_d2  out  DW  read data for ra, rb
- clear_start  in  1  start clear sequence
- clear_busy  out  1  clear sequence active
- rf_reg1, rf_reg2, rf_reg_w  out  AW  register-file addresses
- rf_do_write  out  1  register-file write enable
- rf_write_data  out  DW  register-file write data
- rf_data1, rf_data2  in  DW  register-file read data; the register file updates these on negedge, so they are stable at the following posedge

Behaviour:
- Reset (reset==0 at posedge) sets:
  - state = ARB, clear counter = 0, wait counter = 0
  - rspN_valid = 0, rspN_d1/d2 = 0
  - clear_busy = 0
- While reset==0, the combinational outputs are held low: readys = 0, rf_do_write = 0, rf_reg1/reg2/reg_w = 0, rf_write_data = 0.
- FSM states: ARB, CLEAR.
- ARB:
  - Transaction = one cycle in which reqN_valid && reqN_ready.
  - Classify the requests as read (we=0) or write (we=1).
  - One valid only: that request is granted.
  - Both valid, one read and one write: both are granted in the same cycle.
    - The read samples the register file before the write commits, so it returns the pre-write value (read ordered before write).
  - Both valid, both reads or both writes: port 0 wins (fixed priority); port 1 ready = 0.
  - Granted write: rf_reg_w = wa, rf_write_data = wd, rf_do_write = 1 in that cycle. The write commits at the end of the cycle.
  - Granted read: rf_reg1 = ra, rf_reg2 = rb in that cycle. At the next posedge, rspN_d1/d2 <= rf_data1/rf_data2 and rspN_valid pulses high for exactly 1 cycle.
  - Read latency = 1 cycle. Back-to-back reads are accepted every cycle.
  - Write-then-read to the same address in consecutive cycles returns the new value.
  - With no read granted: rf_reg1/reg2 = 0. With no write granted: rf_do_write = 0.
- clear_start in ARB:
  - Takes precedence over all requests; both readys = 0 in that cycle.
  - Next state = CLEAR, clear_busy = 1.
- CLEAR:
  - Both readys = 0.
  - Each cycle: rf_do_write = 1, rf_reg_w = counter, rf_write_data = 0; counter increments.
  - After counter == NREG-1 is written: counter <= 0, state <= ARB, clear_busy <= 0.
  - Total NREG cycles; clear_start is ignored while busy.
- A read response pending when clear starts is still delivered in the cycle after its grant.
- Reset during CLEAR aborts the sequence: ARB, counter 0. Registers not yet cleared keep their contents.
- Arithmetic: counters are unsigned and wrap naturally. No data is modified by the arbiter except zero fill.

Optional Feature:
- Macro REGARB_STARVE_GUARD_EN.
- Defined:
  - A wait counter increments each cycle port 1 is valid but not granted, saturating at MAX_WAIT.
  - When it equals MAX_WAIT, port 1 wins the next same-type conflict, and the counter clears on the port 1 grant.
  - The counter also clears when port 1 is not valid.
  - Counter state is reset by reset==0.
- Undefined: pure fixed priority to port 0; port 1 may starve indefinitely. No counter logic.

Test Plan:
- Reset, then port 0 writes reg2=0xA5; next cycle port 0 reads ra=2, rb=0 -> rsp0_valid one cycle later, d1=0xA5, d2=0x00.
- Same cycle: port 0 writes reg1=0x3C, port 1 reads ra=1 (old 0x11) -> both ready=1; rsp1 d1=0x11; a following read of reg1 returns 0x3C.
- Both ports issue writes (reg3=0x01 / reg3=0x02) -> port 0 granted, port 1 ready=0; port 1 granted next cycle; final reg3=0x02.
- Load regs 0x11/0x22/0x33/0x44, pulse clear_start -> clear_busy high exactly 4 cycles, readys 0 throughout; afterwards all reads return 0x00.
- Assert reset=0 in the 2nd CLEAR cycle -> clear_busy=0 next cycle, rspN_valid=0; reg0 = 0x00, reg2 keeps 0x33.
- With REGARB_STARVE_GUARD_EN, both ports issue continuous reads -> port 1 granted on the 8th cycle (MAX_WAIT=7); without the macro, port 1 is never granted.
